// File: rtl/efpga_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : efpga_mac_pipe
// Brief    : Pipelined multiply-accumulate with sticky overflow flag.
//            Define EFPGA_MAC_SATURATE_EN to saturate instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module efpga_mac_pipe #(
  parameter int A_WIDTH     = 18,
  parameter int B_WIDTH     = 18,
  parameter int ACC_WIDTH   = 48,
  parameter int A_SIGNED    = 1,
  parameter int B_SIGNED    = 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 acc_clear,
  input  logic                 acc_en,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] y,
  output logic                 ovf
);

  localparam bit c_acc_signed = (A_SIGNED != 0) || (B_SIGNED != 0);

  logic                 r_s1_valid, r_s1_clr, r_s1_en;
  logic [A_WIDTH-1:0]   r_s1_a;
  logic [B_WIDTH-1:0]   r_s1_b;
  logic [ACC_WIDTH-1:0] w_a_ext, w_b_ext, w_prod;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_clr   <= 1'b0;
      r_s1_en    <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_clr   <= acc_clear;
      r_s1_en    <= acc_en;
      r_s1_a     <= a;
      r_s1_b     <= b;
    end
  end

  // Extending both operands to the full width keeps the truncated product exact.
  assign w_a_ext = (A_SIGNED != 0) ? {{(ACC_WIDTH-A_WIDTH){r_s1_a[A_WIDTH-1]}}, r_s1_a}
                                   : {{(ACC_WIDTH-A_WIDTH){1'b0}}, r_s1_a};
  assign w_b_ext = (B_SIGNED != 0) ? {{(ACC_WIDTH-B_WIDTH){r_s1_b[B_WIDTH-1]}}, r_s1_b}
                                   : {{(ACC_WIDTH-B_WIDTH){1'b0}}, r_s1_b};
  assign w_prod  = w_a_ext * w_b_ext;

  logic [ACC_WIDTH-1:0] w_pipe_prod  [PIPE_STAGES];
  logic                 w_pipe_valid [PIPE_STAGES];
  logic                 w_pipe_clr   [PIPE_STAGES];
  logic                 w_pipe_en    [PIPE_STAGES];

  assign w_pipe_prod[0]  = w_prod;
  assign w_pipe_valid[0] = r_s1_valid;
  assign w_pipe_clr[0]   = r_s1_clr;
  assign w_pipe_en[0]    = r_s1_en;

  generate
    for (genvar i = 1; i < PIPE_STAGES; i++) begin : g_pipe
      logic [ACC_WIDTH-1:0] r_prod;
      logic                 r_valid, r_clr, r_en;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_prod  <= '0;
          r_valid <= 1'b0;
          r_clr   <= 1'b0;
          r_en    <= 1'b0;
        end else begin
          r_prod  <= w_pipe_prod[i-1];
          r_valid <= w_pipe_valid[i-1];
          r_clr   <= w_pipe_clr[i-1];
          r_en    <= w_pipe_en[i-1];
        end
      end

      assign w_pipe_prod[i]  = r_prod;
      assign w_pipe_valid[i] = r_valid;
      assign w_pipe_clr[i]   = r_clr;
      assign w_pipe_en[i]    = r_en;
    end
  endgenerate

  logic [ACC_WIDTH-1:0] w_st_prod, w_sum, w_acc_next;
  logic                 w_st_valid, w_st_clr, w_st_en, w_carry, w_acc_ovf;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf, r_out_valid;

  assign w_st_prod  = w_pipe_prod[PIPE_STAGES-1];
  assign w_st_valid = w_pipe_valid[PIPE_STAGES-1];
  assign w_st_clr   = w_pipe_clr[PIPE_STAGES-1];
  assign w_st_en    = w_pipe_en[PIPE_STAGES-1];

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_st_prod};
  assign w_acc_ovf = c_acc_signed
                   ? ((r_acc[ACC_WIDTH-1] == w_st_prod[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]))
                   : w_carry;

`ifdef EFPGA_MAC_SATURATE_EN
  // On signed overflow both addends share a sign, which is the true result's sign.
  logic [ACC_WIDTH-1:0] w_sat;
  assign w_sat = !c_acc_signed        ? {ACC_WIDTH{1'b1}} :
                 r_acc[ACC_WIDTH-1]   ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                        {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign w_acc_next = w_acc_ovf ? w_sat : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= w_st_valid;
      if (w_st_valid) begin
        if (w_st_clr) begin
          r_acc <= w_st_prod;
          r_ovf <= 1'b0;
        end else if (w_st_en) begin
          r_acc <= w_acc_next;
          if (w_acc_ovf) r_ovf <= 1'b1;
        end else begin
          r_acc <= w_st_prod;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_acc;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/efpga_mac_pipe.md
Name: efpga_mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit. Next-generation replacement for the single-cycle combinational multiplier primitive in the Z1010 DSP tile.
- Adds configurable operand widths and signedness, a valid-qualified pipeline of selectable depth, and an accumulator with clear/enable control and a sticky overflow flag.
- Sits in the DSP column. Inferred multipliers and MACs map onto it; fabric logic drives its valid and control inputs.

Parameters:
- A_WIDTH, 18, width of operand a (2..32)
- B_WIDTH, 18, width of operand b (2..32)
- ACC_WIDTH, 48, accumulator/result width; must be >= A_WIDTH+B_WIDTH, and must not exceed A_WIDTH+B_WIDTH+16
- A_SIGNED, 1, 1 = a is two's complement, 0 = unsigned
- B_SIGNED, 1, 1 = b is two's complement, 0 = unsigned
- PIPE_STAGES, 2, multiplier pipeline registers (1..4), including the input register

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  a/b/control are valid this cycle
- a  input  A_WIDTH  multiplicand
- b  input  B_WIDTH  multiplier
- acc_clear  input  1  sample starts a new accumulation: acc = product
- acc_en  input  1  sample adds into accumulator; when acc_en=0 and acc_clear=0, output = product only
- out_valid  output  1  y/ovf valid this cycle
- y  output  ACC_WIDTH  accumulator / product result
- ovf  output  1  sticky accumulator overflow flag

Behaviour:
- Reset (resetn=0, asynchronous):
  - All pipeline valid bits cleared; accumulator cleared.
  - out_valid=0, y=0, ovf=0.
  - Any samples in flight are discarded.
  - Outputs remain at reset values until the first post-reset sample emerges.
- No backpressure: the pipeline advances every cycle. in_valid=0 inserts a bubble.
- Stage 1 registers a, b, in_valid, acc_clear and acc_en. Control bits travel with their sample through every stage.
- Product:
  - Each operand is extended to ACC_WIDTH per its *_SIGNED parameter, then multiplied.
  - The full product is exact; it is never truncated because ACC_WIDTH >= A_WIDTH+B_WIDTH.
  - Product is available after PIPE_STAGES registers.
- Accumulate stage (one further register), for a valid sample:
  - acc_clear=1 (takes priority over acc_en): acc <= product, ovf <= 0.
  - acc_clear=0, acc_en=1: acc <= acc + product, modulo 2^ACC_WIDTH.
  - acc_clear=0, acc_en=0: acc <= product, ovf unchanged.
- Invalid sample at the accumulate stage: acc, y and ovf hold; out_valid=0.
- Latency: a sample accepted at cycle t produces out_valid=1 at cycle t+PIPE_STAGES+1. y = acc register.
- Throughput: one sample per cycle. Back-to-back accumulates chain with no hazard, because the accumulator feedback is single-cycle.
- Overflow, set on an accumulate (acc_en=1, acc_clear=0) whose true sum is not representable in ACC_WIDTH:
  - Signedness rule: the accumulator is signed iff (A_SIGNED or B_SIGNED).
  - Signed: operands' signs equal and result sign differs.
  - Unsigned: carry out of the MSB.
  - ovf is sticky until the next acc_clear sample or reset.
- acc_clear and acc_en both 1: treated as clear.

Optional Feature:
- Macro: EFPGA_MAC_SATURATE_EN.
- Defined: on overflow, acc saturates instead of wrapping.
  - Signed: to the most-positive or most-negative value, by the sign of the true result.
  - Unsigned: to all-ones.
  - ovf is still set. Saturation adds no latency.
- Undefined: modulo wrap as above. No saturation logic is present.

Test Plan:
- Reset/latency: defaults, PIPE_STAGES=2. Hold resetn=0 for 3 cycles → out_valid=0, y=0, ovf=0. Then one sample a=3, b=-4, acc_clear=1 at cycle t → out_valid=1 at t+3, y=-12.
- Accumulate chain: clear sample a=2,b=5, then 3 back-to-back acc_en samples (a=1,b=1), (a=-3,b=2), (a=4,b=4) → y sequence 10, 11, 5, 21, out_valid high 4 consecutive cycles.
- Bubbles: same chain with in_valid=0 gaps between samples → y holds during gaps, final y=21, out_valid=1 exactly 4 times.
- Overflow, unsigned: A_SIGNED=B_SIGNED=0, A_WIDTH=B_WIDTH=8, ACC_WIDTH=16. Clear (255,255) then acc (255,255) → y=0xFC02, ovf=1. Next clear sample (1,1) → y=1, ovf=0. With EFPGA_MAC_SATURATE_EN defined → y=0xFFFF, ovf=1.
- Overflow, signed: same widths with A_SIGNED=B_SIGNED=1. Clear (-128,-128)=16384, then acc (-128,-128) → wrap gives y=0x8000, ovf=1. With EFPGA_MAC_SATURATE_EN defined → y=0x7FFF.
- Reset mid-operation: PIPE_STAGES=4. Issue 3 samples, assert resetn=0 for 1 cycle while they are in flight → none emerge (out_valid stays 0). The next clear sample (a=7,b=6) yields y=42 after 5 cycles.
